cpu_step_ctrl: RTL and testbench

Run/pause/single-step/breakpoint sequencer for the MIPS core on the Nexys4 board. It replaces the gated-clock pause with a registered clock-enable pulse, cpu_ce, that the core's state elements qualify on.
- Front end: synchronises and debounces the step button, divides CLK down to the selected run rate.
- Breakpoint: halts the core when the fetch PC matches a switch-selected address.
- Status outputs feed LEDs and the seven-segment display mux.

---
 rtl/cpu_step_ctrl.sv | 219 +++++++++++++++++++++
 tb/tb_cpu_step_ctrl.sv | 333 +++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/cpu_step_ctrl.sv
`default_nettype none
`timescale 1ns/1ps
// ============================================================================
// Module  : cpu_step_ctrl
// Brief   : Run/pause/single-step/breakpoint sequencer producing a registered
//           one-cycle clock enable (cpu_ce) for the MIPS core.
//           Optional build macro: STEP_CTRL_AUTOREPEAT_EN (hold-to-repeat step).
// Revision: 1.0
// ============================================================================
module cpu_step_ctrl #(
  parameter int unsigned DEBOUNCE_CYCLES = 1000000,
  parameter int unsigned RUN_DIV         = 100000000,
  parameter int unsigned PC_W            = 32
`ifdef STEP_CTRL_AUTOREPEAT_EN
  ,
  parameter int unsigned HOLD_CYCLES     = 50000000
`endif
) (
  input  logic            CLK,
  input  logic            reset_n,
  input  logic            run_sw,
  input  logic            step_btn,
  input  logic [1:0]      rate_sel,
  input  logic [PC_W-1:0] pc,
  input  logic [PC_W-1:0] bp_addr,
  input  logic            bp_en,
  output logic            cpu_ce,
  output logic            halted,
  output logic [1:0]      state,
  output logic            bp_hit,
  output logic [31:0]     ce_count
);

  localparam int unsigned DB_W  = (DEBOUNCE_CYCLES > 1) ? $clog2(DEBOUNCE_CYCLES) : 1;
  localparam int unsigned DIV_W = (RUN_DIV > 1) ? $clog2(RUN_DIV) : 1;

  localparam logic [DB_W-1:0]  c_db_last   = DB_W'(DEBOUNCE_CYCLES - 1);
  localparam logic [DIV_W-1:0] c_term_div1 = DIV_W'(RUN_DIV - 1);
  localparam logic [DIV_W-1:0] c_term_div2 = DIV_W'(RUN_DIV / 10 - 1);
  localparam logic [DIV_W-1:0] c_term_div3 = DIV_W'(RUN_DIV / 100 - 1);

  localparam logic [1:0] c_pause = 2'd0;
  localparam logic [1:0] c_run   = 2'd1;
  localparam logic [1:0] c_step  = 2'd2;
  localparam logic [1:0] c_break = 2'd3;

  logic             r_run_s1, r_run_s;
  logic             r_step_s1, r_step_s;
  logic [DB_W-1:0]  r_db_cnt;
  logic             r_step_db, r_step_db_d;
  logic [1:0]       r_rate_q;
  logic [DIV_W-1:0] r_div_cnt;
  logic [1:0]       r_state;
  logic             r_cpu_ce, r_halted, r_bp_hit, r_need_rel;
  logic [31:0]      r_ce_count;

  logic             w_step_req, w_tick, w_rate_chg, w_div_run, w_div_clr;
  logic [DIV_W-1:0] w_term;
  logic [1:0]       w_state_nx;
  logic             w_ce_nx, w_bp_set, w_bp_clr;

  // Two-flop synchronisers and step debounce
  always_ff @(posedge CLK or negedge reset_n) begin
    if (!reset_n) begin
      r_run_s1    <= 1'b0;
      r_run_s     <= 1'b0;
      r_step_s1   <= 1'b0;
      r_step_s    <= 1'b0;
      r_db_cnt    <= '0;
      r_step_db   <= 1'b0;
      r_step_db_d <= 1'b0;
    end else begin
      r_run_s1    <= run_sw;
      r_run_s     <= r_run_s1;
      r_step_s1   <= step_btn;
      r_step_s    <= r_step_s1;
      r_step_db_d <= r_step_db;
      if (r_step_s != r_step_db) begin
        if (r_db_cnt == c_db_last) begin
          r_step_db <= r_step_s;
          r_db_cnt  <= '0;
        end else begin
          r_db_cnt  <= r_db_cnt + DB_W'(1);
        end
      end else begin
        r_db_cnt <= '0;
      end
    end
  end

  always_comb begin
    w_term = '0;
    case (rate_sel)
      2'b00:   w_term = c_term_div1;
      2'b01:   w_term = c_term_div2;
      2'b10:   w_term = c_term_div3;
      default: w_term = '0;
    endcase
  end

  assign w_rate_chg = (rate_sel != r_rate_q);

`ifdef STEP_CTRL_AUTOREPEAT_EN
  localparam int unsigned HOLD_W = $clog2(HOLD_CYCLES + 1);

  logic [HOLD_W-1:0] r_hold_cnt;
  logic              w_hold_on;

  assign w_hold_on = (r_hold_cnt == HOLD_W'(HOLD_CYCLES));

  // Hold time accumulates across the STEP/PAUSE/BREAK cycles of a long press
  always_ff @(posedge CLK or negedge reset_n) begin
    if (!reset_n) begin
      r_hold_cnt <= '0;
    end else if (!r_step_db || (r_state == c_run)) begin
      r_hold_cnt <= '0;
    end else if (!w_hold_on) begin
      r_hold_cnt <= r_hold_cnt + HOLD_W'(1);
    end
  end

  assign w_div_run  = (r_state == c_run) | w_hold_on;
  assign w_step_req = (r_step_db & ~r_step_db_d) | (w_hold_on & w_tick);
`else
  assign w_div_run  = (r_state == c_run);
  assign w_step_req = r_step_db & ~r_step_db_d;
`endif

  // A rate change restarts the period, so no tick is taken on the change cycle
  assign w_tick    = w_div_run & ~w_rate_chg & (r_div_cnt == w_term);
  assign w_div_clr = ~w_div_run | w_rate_chg | w_tick |
                     ((r_state == c_run) & (w_state_nx != c_run));

  always_ff @(posedge CLK or negedge reset_n) begin
    if (!reset_n) begin
      r_rate_q  <= 2'b00;
      r_div_cnt <= '0;
    end else begin
      r_rate_q  <= rate_sel;
      r_div_cnt <= w_div_clr ? '0 : (r_div_cnt + DIV_W'(1));
    end
  end

  always_comb begin
    w_state_nx = r_state;
    w_ce_nx    = 1'b0;
    w_bp_set   = 1'b0;
    w_bp_clr   = 1'b0;
    case (r_state)
      c_pause: begin
        if (r_run_s && !r_need_rel) begin
          w_state_nx = c_run;
          w_bp_clr   = 1'b1;
        end else if (w_step_req) begin
          w_state_nx = c_step;
        end
      end
      c_run: begin
        if (!r_run_s) begin
          w_state_nx = c_pause;
        end else if (w_tick) begin
          if (bp_en && (pc == bp_addr)) begin
            w_state_nx = c_break;
            w_bp_set   = 1'b1;
          end else begin
            w_ce_nx = 1'b1;
          end
        end
      end
      c_step: begin
        w_ce_nx    = 1'b1;
        w_state_nx = c_pause;
      end
      default: begin
        if (!r_run_s) begin
          w_state_nx = c_pause;
        end else if (w_step_req) begin
          w_state_nx = c_step;
        end
      end
    endcase
  end

  // r_need_rel forces a run-switch release after a breakpoint before RUN resumes
  always_ff @(posedge CLK or negedge reset_n) begin
    if (!reset_n) begin
      r_state    <= c_pause;
      r_cpu_ce   <= 1'b0;
      r_halted   <= 1'b1;
      r_bp_hit   <= 1'b0;
      r_need_rel <= 1'b0;
      r_ce_count <= '0;
    end else begin
      r_state    <= w_state_nx;
      r_cpu_ce   <= w_ce_nx;
      r_halted   <= (w_state_nx != c_run);
      r_ce_count <= r_ce_count + 32'(r_cpu_ce);
      if (w_bp_set) begin
        r_bp_hit <= 1'b1;
      end else if (w_bp_clr) begin
        r_bp_hit <= 1'b0;
      end
      if (w_bp_set) begin
        r_need_rel <= 1'b1;
      end else if (!r_run_s) begin
        r_need_rel <= 1'b0;
      end
    end
  end

  assign cpu_ce   = r_cpu_ce;
  assign halted   = r_halted;
  assign state    = r_state;
  assign bp_hit   = r_bp_hit;
  assign ce_count = r_ce_count;

endmodule

`default_nettype wire

// File: tb/tb_cpu_step_ctrl.sv
`default_nettype none
`timescale 1ns/1ps
// ============================================================================
// Module  : tb_cpu_step_ctrl
// Brief   : Self-checking bench for cpu_step_ctrl with a behavioural model.
// Revision: 1.0
// ============================================================================
module tb_cpu_step_ctrl;

  localparam int unsigned DEB = 4;
  localparam int unsigned DIV = 100;
  localparam logic [1:0] ST_PAUSE = 2'd0;
  localparam logic [1:0] ST_RUN   = 2'd1;
  localparam logic [1:0] ST_STEP  = 2'd2;
  localparam logic [1:0] ST_BREAK = 2'd3;

  logic        CLK = 1'b0;
  logic        reset_n = 1'b0;
  logic        run_sw = 1'b0;
  logic        step_btn = 1'b0;
  logic [1:0]  rate_sel = 2'b00;
  logic [31:0] pc = '0;
  logic [31:0] bp_addr = '0;
  logic        bp_en = 1'b0;
  logic        cpu_ce, halted, bp_hit;
  logic [1:0]  state;
  logic [31:0] ce_count;

  int checks = 0;
  int failures = 0;
  bit pc_follow = 1'b0;

  // Behavioural model state
  bit          m_run_q[$];
  bit          m_step_q[$];
  bit          m_hist[$];
  bit          m_db, m_db_prev, m_armed;
  logic [1:0]  m_state, m_rate_prev;
  bit          m_ce, m_halted, m_bp;
  logic [31:0] m_count;
  int          m_cyc, m_seg;

  cpu_step_ctrl #(
    .DEBOUNCE_CYCLES(DEB),
    .RUN_DIV        (DIV),
    .PC_W           (32)
  ) dut (
    .CLK     (CLK),
    .reset_n (reset_n),
    .run_sw  (run_sw),
    .step_btn(step_btn),
    .rate_sel(rate_sel),
    .pc      (pc),
    .bp_addr (bp_addr),
    .bp_en   (bp_en),
    .cpu_ce  (cpu_ce),
    .halted  (halted),
    .state   (state),
    .bp_hit  (bp_hit),
    .ce_count(ce_count)
  );

  always #5 CLK = ~CLK;

  function automatic int period_of(logic [1:0] r);
    case (r)
      2'b00:   return int'(DIV);
      2'b01:   return int'(DIV / 10);
      2'b10:   return int'(DIV / 100);
      default: return 1;
    endcase
  endfunction

  task automatic model_reset();
    m_run_q = {1'b0, 1'b0};
    m_step_q = {1'b0, 1'b0};
    m_hist = {};
    m_db = 0; m_db_prev = 0; m_armed = 1;
    m_state = ST_PAUSE; m_rate_prev = 2'b00;
    m_ce = 0; m_halted = 1; m_bp = 0; m_count = '0;
    m_cyc = 0; m_seg = 0;
  endtask

  // Advances the model by one clock edge using the inputs held during the cycle.
  task automatic model_step();
    bit run_s, step_s, step_req, tick, rate_chg, flip, ce, to_break;
    logic [1:0] ns;
    int n, k;
    k = m_cyc;
    run_s  = m_run_q[0];
    step_s = m_step_q[0];
    m_run_q  = {m_run_q[1], run_sw};
    m_step_q = {m_step_q[1], step_btn};
    m_hist.push_back(step_s);
    if (m_hist.size() > int'(DEB)) m_hist.delete(0);
    flip = (m_hist.size() == int'(DEB));
    foreach (m_hist[i]) if (m_hist[i] == m_db) flip = 0;
    step_req = m_db && !m_db_prev;
    rate_chg = (rate_sel != m_rate_prev);
    n = period_of(rate_sel);
    tick = (m_state == ST_RUN) && !rate_chg && (((k - m_seg) % n) == n - 1);
    ns = m_state; ce = 0; to_break = 0;
    case (m_state)
      ST_PAUSE: begin
        if (run_s && m_armed) begin ns = ST_RUN; m_bp = 0; end
        else if (step_req) ns = ST_STEP;
      end
      ST_RUN: begin
        if (!run_s) ns = ST_PAUSE;
        else if (tick) begin
          if (bp_en && pc == bp_addr) begin ns = ST_BREAK; m_bp = 1; to_break = 1; end
          else ce = 1;
        end
      end
      ST_STEP: begin ce = 1; ns = ST_PAUSE; end
      default: begin
        if (!run_s) ns = ST_PAUSE;
        else if (step_req) ns = ST_STEP;
      end
    endcase
    if (to_break) m_armed = 0;
    else if (!run_s) m_armed = 1;
    m_count = m_count + 32'(m_ce);
    m_ce = ce;
    m_halted = (ns != ST_RUN);
    if (ns == ST_RUN && (m_state != ST_RUN || rate_chg)) m_seg = k + 1;
    m_state = ns;
    m_rate_prev = rate_sel;
    m_db_prev = m_db;
    if (flip) m_db = !m_db;
    m_cyc = k + 1;
  endtask

  task automatic cycle();
    bit ce_was;
    ce_was = m_ce;
    @(posedge CLK);
    model_step();
    #1;
    if (pc_follow && ce_was) pc = pc + 32'd4;
  endtask

  task automatic do_reset();
    reset_n = 1'b0;
    run_sw = 0; step_btn = 0; rate_sel = 2'b00;
    bp_en = 0; bp_addr = '0; pc = '0; pc_follow = 0;
    model_reset();
    repeat (2) @(posedge CLK);
    #1;
    reset_n = 1'b1;
  endtask

  task automatic test_reset();
    reset_n = 1'b0;
    repeat (2) @(posedge CLK);
    #1;
    checks++; if (cpu_ce !== 1'b0) begin failures++; $display("FAIL reset_cpu_ce: got %b expected 0", cpu_ce); end
    checks++; if (state !== ST_PAUSE) begin failures++; $display("FAIL reset_state: got %0d expected 0", state); end
    checks++; if (halted !== 1'b1) begin failures++; $display("FAIL reset_halted: got %b expected 1", halted); end
    checks++; if (bp_hit !== 1'b0) begin failures++; $display("FAIL reset_bp_hit: got %b expected 0", bp_hit); end
    checks++; if (ce_count !== 32'd0) begin failures++; $display("FAIL reset_ce_count: got %0d expected 0", ce_count); end
    do_reset();
  endtask

  task automatic test_run();
    int pulses, wide, first, entry;
    bit prev;
    pulses = 0; wide = 0; first = -1; entry = -1; prev = 0;
    do_reset();
    run_sw = 1; rate_sel = 2'b00;
    for (int i = 0; i < 1010; i++) begin
      cycle();
      if (entry < 0 && state === ST_RUN) entry = i;
      if (cpu_ce === 1'b1) begin
        pulses++;
        if (first < 0) first = i;
        if (prev) wide++;
      end
      prev = (cpu_ce === 1'b1);
    end
    checks++; if (pulses != 10) begin failures++; $display("FAIL run_pulses: got %0d expected 10", pulses); end
    checks++; if (first - entry != int'(DIV)) begin failures++; $display("FAIL run_first_latency: got %0d expected %0d", first - entry, DIV); end
    checks++; if (wide != 0) begin failures++; $display("FAIL run_pulse_width: got %0d wide pulses expected 0", wide); end
    checks++; if (ce_count !== 32'd10) begin failures++; $display("FAIL run_ce_count: got %0d expected 10", ce_count); end
    checks++; if (ce_count !== m_count) begin failures++; $display("FAIL run_model_count: got %0d expected %0d", ce_count, m_count); end
    checks++; if (halted !== 1'b0) begin failures++; $display("FAIL run_halted: got %b expected 0", halted); end
  endtask

  task automatic test_step_debounce();
    bit pat[$];
    int pulses;
    bit saw_step;
    do_reset();
    repeat (5) cycle();
    pat = {1'b1, 1'b1, 1'b0, 1'b0};
    repeat (12) pat.push_back(1'b1);
    repeat (14) pat.push_back(1'b0);
    pulses = 0; saw_step = 0;
    foreach (pat[i]) begin
      step_btn = pat[i];
      cycle();
      if (cpu_ce === 1'b1) pulses++;
      if (state === ST_STEP) saw_step = 1;
    end
    checks++; if (pulses != 1) begin failures++; $display("FAIL step_pulses: got %0d expected 1", pulses); end
    checks++; if (!saw_step) begin failures++; $display("FAIL step_state_seen: got 0 expected 1"); end
    checks++; if (state !== ST_PAUSE) begin failures++; $display("FAIL step_final_state: got %0d expected 0", state); end
    checks++; if (ce_count !== 32'd1) begin failures++; $display("FAIL step_ce_count: got %0d expected 1", ce_count); end
  endtask

  task automatic test_breakpoint();
    logic [31:0] pcs[$];
    int pulses, i;
    do_reset();
    bp_en = 1; bp_addr = 32'h0000000C; rate_sel = 2'b01; pc_follow = 1; run_sw = 1;
    i = 0;
    while (i < 300 && state !== ST_BREAK) begin
      cycle();
      if (cpu_ce === 1'b1) pcs.push_back(pc);
      i++;
    end
    checks++; if (state !== ST_BREAK) begin failures++; $display("FAIL bp_reach_break: got state %0d expected 3 within 300 cycles", state); end
    checks++; if (pcs.size() != 3) begin failures++; $display("FAIL bp_pulses: got %0d expected 3", pcs.size()); end
    else begin
      checks++;
      if (pcs[0] !== 32'h0 || pcs[1] !== 32'h4 || pcs[2] !== 32'h8) begin
        failures++; $display("FAIL bp_pulse_pcs: got %0h %0h %0h expected 0 4 8", pcs[0], pcs[1], pcs[2]);
      end
    end
    checks++; if (bp_hit !== 1'b1) begin failures++; $display("FAIL bp_hit_set: got %b expected 1", bp_hit); end
    checks++; if (pc !== 32'hC) begin failures++; $display("FAIL bp_pc_hold: got %0h expected c", pc); end
    pulses = 0;
    repeat (30) begin cycle(); if (cpu_ce === 1'b1) pulses++; end
    checks++; if (pulses != 0 || state !== ST_BREAK) begin failures++; $display("FAIL bp_hold: got %0d pulses state %0d expected 0 pulses state 3", pulses, state); end
  endtask

  task automatic test_break_step_resume();
    int pulses;
    bit saw_step;
    pulses = 0; saw_step = 0;
    step_btn = 1;
    repeat (8) begin cycle(); if (cpu_ce === 1'b1) pulses++; if (state === ST_STEP) saw_step = 1; end
    step_btn = 0;
    repeat (10) begin cycle(); if (cpu_ce === 1'b1) pulses++; if (state === ST_STEP) saw_step = 1; end
    checks++; if (pulses != 1 || !saw_step) begin failures++; $display("FAIL brk_step: got %0d pulses step_seen %b expected 1 pulse step_seen 1", pulses, saw_step); end
    checks++; if (state !== ST_PAUSE) begin failures++; $display("FAIL brk_step_pause: got %0d expected 0", state); end
    checks++; if (ce_count !== 32'd4 || pc !== 32'h10) begin failures++; $display("FAIL brk_step_count: got count %0d pc %0h expected 4 10", ce_count, pc); end
    run_sw = 0;
    repeat (4) cycle();
    run_sw = 1;
    repeat (5) cycle();
    checks++; if (state !== ST_RUN || halted !== 1'b0) begin failures++; $display("FAIL brk_resume: got state %0d halted %b expected 1 0", state, halted); end
    checks++; if (bp_hit !== 1'b0) begin failures++; $display("FAIL brk_bp_clear: got %b expected 0", bp_hit); end
  endtask

  task automatic test_rate_change();
    int i, n;
    do_reset();
    run_sw = 1; rate_sel = 2'b00;
    i = 0;
    while (i < 300 && !(m_state == ST_RUN && ((m_cyc - m_seg) % int'(DIV)) == 57)) begin
      cycle(); i++;
    end
    rate_sel = 2'b01;
    n = 0;
    do begin cycle(); n++; end while (cpu_ce !== 1'b1 && n < 50);
    checks++; if (n != 1 + int'(DIV / 10)) begin failures++; $display("FAIL rate_change_latency: got %0d expected %0d", n, 1 + DIV / 10); end
    rate_sel = 2'b11;
    repeat (2) cycle();
    for (int j = 0; j < 8; j++) begin
      cycle();
      checks++; if (cpu_ce !== 1'b1) begin failures++; $display("FAIL rate_every_cycle[%0d]: got %b expected 1", j, cpu_ce); end
    end
  endtask

  task automatic test_async_reset();
    cycle();
    checks++; if (cpu_ce !== 1'b1 || ce_count !== m_count) begin failures++; $display("FAIL areset_pre: got ce %b count %0d expected 1 %0d", cpu_ce, ce_count, m_count); end
    #3;
    reset_n = 1'b0;
    #1;
    checks++; if (cpu_ce !== 1'b0) begin failures++; $display("FAIL areset_cpu_ce: got %b expected 0", cpu_ce); end
    checks++; if (state !== ST_PAUSE) begin failures++; $display("FAIL areset_state: got %0d expected 0", state); end
    checks++; if (ce_count !== 32'd0) begin failures++; $display("FAIL areset_ce_count: got %0d expected 0", ce_count); end
    checks++; if (halted !== 1'b1) begin failures++; $display("FAIL areset_halted: got %b expected 1", halted); end
    do_reset();
  endtask

  task automatic test_random();
    do_reset();
    pc_follow = 1;
    rate_sel = 2'b11;
    for (int i = 0; i < 3000; i++) begin
      if ($urandom_range(0, 15) == 0) run_sw = ~run_sw;
      if ($urandom_range(0, 5) == 0) step_btn = ~step_btn;
      if ($urandom_range(0, 63) == 0) rate_sel = 2'($urandom_range(0, 3));
      if ($urandom_range(0, 99) == 0) begin
        bp_en = 1'($urandom_range(0, 1));
        bp_addr = pc + 32'(4 * $urandom_range(0, 3));
      end
      cycle();
      checks++;
      if ({cpu_ce, halted, state, bp_hit, ce_count} !== {m_ce, m_halted, m_state, m_bp, m_count}) begin
        failures++;
        $display("FAIL random[%0d]: got ce=%b st=%0d halt=%b bp=%b cnt=%0d expected ce=%b st=%0d halt=%b bp=%b cnt=%0d",
                 i, cpu_ce, state, halted, bp_hit, ce_count, m_ce, m_state, m_halted, m_bp, m_count);
      end
    end
  endtask

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    model_reset();
    test_reset();
    test_run();
    test_step_debounce();
    test_breakpoint();
    test_break_step_resume();
    test_rate_change();
    test_async_reset();
    test_random();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

`default_nettype wire
